nios2_qsys_mul_shift_issue: RTL and testbench
=============================================

Name: nios2_qsys_mul_shift_issue

Overview:
- E-stage issue and tracking stage directly upstream of the Nios II multiplier cell (altmult_add: 32x32, input regs on M_en, output/rotate/shift_right regs on A_en).
- Decodes multiply, multiply-extended, shift and rotate ops into the cell's operands and sign controls. Shifts and rotates are executed as multiplies by powers of two.
- Registers M-stage rotate/shift_right controls and tracks op validity through M and A, so the A-stage mux knows when A_mul_cell_result is live.

Parameters:
- OP_W, 4, op code width.
- LATENCY_CHECK, 1, 1 = include the registered illegal-op flag path.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- E_valid  in  1  E-stage op present
- E_op  in  4  0 MUL, 1 MULXSS, 2 MULXSU, 3 MULXUU, 4 SLL, 5 SRL, 6 SRA, 7 ROL, 8 ROR; others illegal
- E_src1  in  32  operand A / shift data
- E_src2  in  32  operand B; bits [4:0] are the shift amount n for ops 4-8
- M_en  in  1  E->M advance (also the cell's ena0)
- A_en  in  1  M->A advance (also the cell's ena1)
- A_flush  in  1  kill ops in M and A
- E_src1_mul_cell  out  32  cell dataa
- E_src2_mul_cell  out  32  cell datab
- E_ctrl_mul_shift_src1_signed  out  1  cell signa
- E_ctrl_mul_shift_src2_signed  out  1  cell signb
- M_mul_cell_rotate  out  1  cell rotate
- M_mul_cell_shift_right  out  1  cell shift_right
- A_mul_cell_result  in  32  cell result
- A_result  out  32  result to A-stage mux
- A_result_valid  out  1  A_result holds a legal completed op
- A_illegal  out  1  op now in A had an illegal code

Behaviour:
- Cell semantics: P = src1 x src2 (64b, signedness per signa/signb).
  - Result = P[31:0] normally.
  - Result = P[63:32] when shift_right = 1.
  - Result = P[31:0] | P[63:32] when rotate = 1.
- E-stage decode is combinational. Each line gives src1 / src2 / signa / signb / shift_right / rotate:
  - MUL: E_src1 / E_src2 / 0 / 0 / 0 / 0.
  - MULXSS: E_src1 / E_src2 / 1 / 1 / 1 / 0.
  - MULXSU: E_src1 / E_src2 / 1 / 0 / 1 / 0.
  - MULXUU: E_src1 / E_src2 / 0 / 0 / 1 / 0.
  - SLL: E_src1 / 1<<n / 0 / 0 / 0 / 0.
  - SRL, n>0: E_src1 / 1<<(32-n) / 0 / 0 / 1 / 0.
  - SRA, n>0: E_src1 / 1<<(32-n) / 1 / 0 / 1 / 0.
  - SRL or SRA, n=0: src2 = 1, shift_right = 0 (avoids the 1<<32 overflow).
  - ROL: src2 = 1<<n, rotate = 1. n=0 yields P = src1 with P[63:32] = 0, so no special case.
  - ROR: src2 = 1<<((32-n)&31), rotate = 1.
  - Illegal op: operands 0, all controls 0.
- E outputs are driven regardless of E_valid. The cell samples them on the clk edge where M_en=1.
- M registers (M_valid, M_illegal, M_mul_cell_rotate, M_mul_cell_shift_right):
  - Load on edge with M_en=1: M_valid <= E_valid.
  - Hold when M_en=0.
- A registers (A_valid, A_illegal_r):
  - Load from M on edge with A_en=1.
  - Hold when A_en=0.
- Outputs:
  - A_result = A_mul_cell_result (combinational pass).
  - A_result_valid = A_valid & ~A_illegal_r.
  - A_illegal = A_valid & A_illegal_r (forced 0 when LATENCY_CHECK=0).
- Latency: with M_en = A_en = 1, an op presented in cycle t is valid in cycle t+2.
- Stalls:
  - M_en=0, A_en=1: the M op stays, the A slot takes a bubble (A_valid <= 0 only if M_en=0 and the M op did not advance). Rule: A loads M contents only when A_en=1 and M_en=1, otherwise A_valid clears when A_en=1.
  - Both 0: everything holds.
  - A_result_valid asserts exactly once per issued op, provided A_en=1 in its A cycle.
- A_flush (synchronous): clears M_valid and A_valid next edge, overriding M_en/A_en loads. E_valid in the same cycle is still captured into M only if M_en=1 and A_flush=0.
- Reset (async, reset_n=0): all M/A registers 0, so A_result_valid = 0 and A_illegal = 0. The cell is cleared by the same reset. Reset mid-op discards the op; no completion after deassert.

Test Plan:
- MUL 7 x 0xFFFFFFFD, enables high -> A_result_valid at t+2, A_result = 0xFFFFFFEB.
- MULXSS 0x80000000 x 0x80000000 -> 0x40000000. MULXUU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULXSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- src1 = 0x80000010: SRL n=4 -> 0x08000001 (src2 = 0x10000000, shift_right = 1). SRA n=4 -> 0xF8000001. SRA n=0 -> 0x80000010 (src2 = 1, shift_right = 0). SLL n=31 -> 0x00000000.
- 0x12345678: ROR n=8 -> 0x78123456. ROL n=4 -> 0x23456781. ROL n=0 -> 0x12345678.
- Back-to-back MUL then SRL, M_en=0 for 3 cycles while SRL sits in M -> M controls hold, SRL completes once with correct value, no duplicate valid.
- Op code 0xF -> A_illegal = 1, A_result_valid = 0. A_flush with ops in M and A -> neither completes. reset_n pulsed low mid-op -> all valids 0 immediately.

Source files
------------

// File: rtl/nios2_qsys_mul_shift_issue_if.sv
// E-stage to multiplier-cell issue bus: operands and stage enables in, cell controls and A-stage status out.
interface nios2_qsys_mul_shift_issue_if #(
    parameter int OP_W = 4
);
    logic            E_valid;
    logic [OP_W-1:0] E_op;
    logic [31:0]     E_src1;
    logic [31:0]     E_src2;
    logic            M_en;
    logic            A_en;
    logic            A_flush;
    logic [31:0]     A_mul_cell_result;

    logic [31:0]     E_src1_mul_cell;
    logic [31:0]     E_src2_mul_cell;
    logic            E_ctrl_mul_shift_src1_signed;
    logic            E_ctrl_mul_shift_src2_signed;
    logic            M_mul_cell_rotate;
    logic            M_mul_cell_shift_right;
    logic [31:0]     A_result;
    logic            A_result_valid;
    logic            A_illegal;

    modport master (
        output E_valid, E_op, E_src1, E_src2, M_en, A_en, A_flush, A_mul_cell_result,
        input  E_src1_mul_cell, E_src2_mul_cell, E_ctrl_mul_shift_src1_signed,
               E_ctrl_mul_shift_src2_signed, M_mul_cell_rotate, M_mul_cell_shift_right,
               A_result, A_result_valid, A_illegal
    );

    modport slave (
        input  E_valid, E_op, E_src1, E_src2, M_en, A_en, A_flush, A_mul_cell_result,
        output E_src1_mul_cell, E_src2_mul_cell, E_ctrl_mul_shift_src1_signed,
               E_ctrl_mul_shift_src2_signed, M_mul_cell_rotate, M_mul_cell_shift_right,
               A_result, A_result_valid, A_illegal
    );
endinterface

// File: rtl/nios2_qsys_mul_shift_issue.sv
// Issue stage for the 32x32 multiplier cell: maps mul/shift/rotate ops onto multiplies by
// powers of two and tracks op validity through M and A so the A-stage mux knows when the cell result is live.
module nios2_qsys_mul_shift_issue #(
    parameter int OP_W          = 4,
    parameter bit LATENCY_CHECK = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    nios2_qsys_mul_shift_issue_if.slave   bus
);
    localparam logic [OP_W-1:0] OP_MUL    = OP_W'(0);
    localparam logic [OP_W-1:0] OP_MULXSS = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MULXSU = OP_W'(2);
    localparam logic [OP_W-1:0] OP_MULXUU = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SLL    = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SRL    = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SRA    = OP_W'(6);
    localparam logic [OP_W-1:0] OP_ROL    = OP_W'(7);
    localparam logic [OP_W-1:0] OP_ROR    = OP_W'(8);

    logic [4:0]  w_n;
    logic [4:0]  w_n_inv;
    logic [31:0] w_pow_l;
    logic [31:0] w_pow_r;
    logic        w_n_zero;

    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic        w_sign1;
    logic        w_sign2;
    logic        w_shift_right;
    logic        w_rotate;
    logic        w_illegal;

    logic        r_m_valid;
    logic        r_m_illegal;
    logic        r_m_rotate;
    logic        r_m_shift_right;
    logic        r_a_valid;
    logic        r_a_illegal;

    // (32-n) mod 32 is just -n in 5 bits; n=0 therefore maps to 1<<0 for the right-shift forms.
    assign w_n      = bus.E_src2[4:0];
    assign w_n_inv  = 5'd0 - w_n;
    assign w_n_zero = (w_n == 5'd0);
    assign w_pow_l  = 32'd1 << w_n;
    assign w_pow_r  = 32'd1 << w_n_inv;

    always_comb begin
        w_src1        = 32'd0;
        w_src2        = 32'd0;
        w_sign1       = 1'b0;
        w_sign2       = 1'b0;
        w_shift_right = 1'b0;
        w_rotate      = 1'b0;
        w_illegal     = 1'b0;
        case (bus.E_op)
            OP_MUL: begin
                w_src1 = bus.E_src1;
                w_src2 = bus.E_src2;
            end
            OP_MULXSS: begin
                w_src1        = bus.E_src1;
                w_src2        = bus.E_src2;
                w_sign1       = 1'b1;
                w_sign2       = 1'b1;
                w_shift_right = 1'b1;
            end
            OP_MULXSU: begin
                w_src1        = bus.E_src1;
                w_src2        = bus.E_src2;
                w_sign1       = 1'b1;
                w_shift_right = 1'b1;
            end
            OP_MULXUU: begin
                w_src1        = bus.E_src1;
                w_src2        = bus.E_src2;
                w_shift_right = 1'b1;
            end
            OP_SLL: begin
                w_src1 = bus.E_src1;
                w_src2 = w_pow_l;
            end
            OP_SRL: begin
                w_src1        = bus.E_src1;
                w_src2        = w_pow_r;
                w_shift_right = ~w_n_zero;
            end
            OP_SRA: begin
                w_src1        = bus.E_src1;
                w_src2        = w_pow_r;
                w_sign1       = 1'b1;
                w_shift_right = ~w_n_zero;
            end
            OP_ROL: begin
                w_src1   = bus.E_src1;
                w_src2   = w_pow_l;
                w_rotate = 1'b1;
            end
            OP_ROR: begin
                w_src1   = bus.E_src1;
                w_src2   = w_pow_r;
                w_rotate = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign bus.E_src1_mul_cell              = w_src1;
    assign bus.E_src2_mul_cell              = w_src2;
    assign bus.E_ctrl_mul_shift_src1_signed = w_sign1;
    assign bus.E_ctrl_mul_shift_src2_signed = w_sign2;

    // M-stage controls follow the cell's input registers, so they load on M_en only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_rotate      <= 1'b0;
            r_m_shift_right <= 1'b0;
            r_m_illegal     <= 1'b0;
        end else if (bus.M_en) begin
            r_m_rotate      <= w_rotate;
            r_m_shift_right <= w_shift_right;
            r_m_illegal     <= w_illegal;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_valid <= 1'b0;
        end else if (bus.A_flush) begin
            r_m_valid <= 1'b0;
        end else if (bus.M_en) begin
            r_m_valid <= bus.E_valid;
        end
    end

    // A only takes the M op when both stages advance; A_en alone inserts a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_valid   <= 1'b0;
            r_a_illegal <= 1'b0;
        end else begin
            if (bus.A_flush) begin
                r_a_valid <= 1'b0;
            end else if (bus.A_en) begin
                r_a_valid <= bus.M_en & r_m_valid;
            end
            if (bus.A_en) begin
                r_a_illegal <= bus.M_en & r_m_illegal;
            end
        end
    end

    assign bus.M_mul_cell_rotate      = r_m_rotate;
    assign bus.M_mul_cell_shift_right = r_m_shift_right;
    assign bus.A_result               = bus.A_mul_cell_result;
    assign bus.A_result_valid         = r_a_valid & ~r_a_illegal;

    generate
        if (LATENCY_CHECK) begin : g_ill
            assign bus.A_illegal = r_a_valid & r_a_illegal;
        end else begin : g_no_ill
            assign bus.A_illegal = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_nios2_qsys_mul_shift_issue.sv
// Scoreboard bench: models the multiplier cell, issues directed and random ops, checks completions.
module tb_nios2_qsys_mul_shift_issue;
    logic clk;
    logic reset_n;
    int   cyc;
    int   total;
    int   bad;

    typedef struct {
        logic [31:0] res;
        bit          ill;
        int          due;
    } exp_t;
    exp_t sb[$];

    nios2_qsys_mul_shift_issue_if #(.OP_W(4)) bus ();

    nios2_qsys_mul_shift_issue #(.OP_W(4), .LATENCY_CHECK(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] cell_fn(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb_,
                                            input logic rot, input logic sr);
        logic [63:0] ea, eb, p;
        ea = sa  ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sb_ ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        if (rot)     return p[31:0] | p[63:32];
        else if (sr) return p[63:32];
        else         return p[31:0];
    endfunction

    // Multiplier cell: input regs on M_en, output reg on A_en, cleared by reset.
    logic [31:0] c_a, c_b;
    logic        c_sa, c_sb;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_a <= '0; c_b <= '0; c_sa <= 1'b0; c_sb <= 1'b0;
            bus.A_mul_cell_result <= '0;
        end else begin
            if (bus.M_en) begin
                c_a  <= bus.E_src1_mul_cell;
                c_b  <= bus.E_src2_mul_cell;
                c_sa <= bus.E_ctrl_mul_shift_src1_signed;
                c_sb <= bus.E_ctrl_mul_shift_src2_signed;
            end
            if (bus.A_en)
                bus.A_mul_cell_result <= cell_fn(c_a, c_b, c_sa, c_sb,
                                                 bus.M_mul_cell_rotate, bus.M_mul_cell_shift_right);
        end
    end

    function automatic logic [31:0] ref_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  n;
        logic [63:0] p;
        n = b[4:0];
        case (op)
            4'd0: return a * b;
            4'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            4'd2: begin p = {{32{a[31]}}, a} * {32'd0, b};       return p[63:32]; end
            4'd3: begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
            4'd4: return a << n;
            4'd5: return a >> n;
            4'd6: return 32'($signed(a) >>> n);
            4'd7: begin p = {a, a} << n; return p[63:32]; end
            4'd8: begin p = {a, a} >> n; return p[31:0]; end
            default: return 32'd0;
        endcase
    endfunction

    // Completion monitor: an op completes when A shows valid or illegal with A_en high.
    always @(negedge clk) begin
        if (reset_n && bus.A_en && (bus.A_result_valid || bus.A_illegal)) begin
            if (sb.size() == 0) begin
                chk("spurious_completion", {31'd0, bus.A_result_valid | bus.A_illegal}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("a_illegal", {31'd0, bus.A_illegal}, {31'd0, e.ill});
                chk("a_valid", {31'd0, bus.A_result_valid}, {31'd0, ~e.ill});
                if (!e.ill) chk("a_result", bus.A_result, e.res);
                if (e.due >= 0) chk("latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.E_valid = 1'b1;
        bus.E_op    = op;
        bus.E_src1  = a;
        bus.E_src2  = b;
        @(posedge clk); #1;
        bus.E_valid = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input bit ill, input bit timed);
        exp_t e;
        e.res = res;
        e.ill = ill;
        e.due = timed ? cyc + 2 : -1;
        sb.push_back(e);
        drive_op(op, a, b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        cyc = 0; total = 0; bad = 0;
        reset_n     = 1'b0;
        bus.E_valid = 1'b0; bus.E_op = '0; bus.E_src1 = '0; bus.E_src2 = '0;
        bus.M_en    = 1'b1; bus.A_en = 1'b1; bus.A_flush = 1'b0;
        idle(2);
        chk("rst_valid",   {31'd0, bus.A_result_valid}, 32'd0);
        chk("rst_illegal", {31'd0, bus.A_illegal}, 32'd0);
        chk("rst_sr",      {31'd0, bus.M_mul_cell_shift_right}, 32'd0);
        chk("rst_rot",     {31'd0, bus.M_mul_cell_rotate}, 32'd0);
        reset_n = 1'b1;
        idle(1);

        // directed vectors, enables high, back to back
        issue(4'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b1);
        issue(4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b1);
        issue(4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1);
        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
        issue(4'd5, 32'h80000010, 32'd4,        32'h08000001, 1'b0, 1'b1);
        issue(4'd6, 32'h80000010, 32'd4,        32'hF8000001, 1'b0, 1'b1);
        issue(4'd6, 32'h80000010, 32'd0,        32'h80000010, 1'b0, 1'b1);
        issue(4'd4, 32'h80000010, 32'd31,       32'h00000000, 1'b0, 1'b1);
        issue(4'd8, 32'h12345678, 32'd8,        32'h78123456, 1'b0, 1'b1);
        issue(4'd7, 32'h12345678, 32'd4,        32'h23456781, 1'b0, 1'b1);
        issue(4'd7, 32'h12345678, 32'd0,        32'h12345678, 1'b0, 1'b1);
        issue(4'hF, 32'h12345678, 32'd3,        32'h0,        1'b1, 1'b1);
        idle(3);

        // random ops against the reference semantics
        for (int i = 0; i < 24; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 8));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
            issue(op, a, b, ref_fn(op, a, b), 1'b0, 1'b1);
        end
        idle(3);

        // decode spot checks on the combinational E outputs
        bus.E_op = 4'd5; bus.E_src1 = 32'h80000010; bus.E_src2 = 32'd4; #1;
        chk("srl_src2", bus.E_src2_mul_cell, 32'h10000000);
        bus.E_op = 4'd6; bus.E_src2 = 32'd0; #1;
        chk("sra0_src2", bus.E_src2_mul_cell, 32'd1);
        bus.E_op = 4'd1; bus.E_src2 = 32'h5; #1;
        chk("mulxss_signb", {31'd0, bus.E_ctrl_mul_shift_src2_signed}, 32'd1);
        idle(1);

        // MUL then SRL, SRL held in M for three cycles
        issue(4'd0, 32'd3, 32'd5, 32'd15, 1'b0, 1'b1);
        issue(4'd5, 32'h80000010, 32'd4, 32'h08000001, 1'b0, 1'b0);
        bus.M_en = 1'b0;
        bus.E_op = 4'd0; bus.E_src2 = 32'd0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_sr_hold", {31'd0, bus.M_mul_cell_shift_right}, 32'd1);
            @(posedge clk); #1;
        end
        bus.M_en = 1'b1;
        idle(4);
        chk("stall_drained", 32'(sb.size()), 32'd0);

        // flush with ops in M and A
        drive_op(4'd0, 32'd9, 32'd9);
        drive_op(4'hF, 32'd1, 32'd1);
        bus.A_flush = 1'b1; bus.A_en = 1'b0; bus.M_en = 1'b0;
        idle(1);
        bus.A_flush = 1'b0; bus.A_en = 1'b1; bus.M_en = 1'b1;
        chk("flush_valid",   {31'd0, bus.A_result_valid}, 32'd0);
        chk("flush_illegal", {31'd0, bus.A_illegal}, 32'd0);
        idle(4);

        // reset pulsed mid-op
        drive_op(4'd3, 32'hFFFFFFFF, 32'd2);
        drive_op(4'd5, 32'h80000000, 32'd1);
        reset_n = 1'b0; #1;
        chk("midrst_valid",   {31'd0, bus.A_result_valid}, 32'd0);
        chk("midrst_illegal", {31'd0, bus.A_illegal}, 32'd0);
        chk("midrst_sr",      {31'd0, bus.M_mul_cell_shift_right}, 32'd0);
        idle(1);
        reset_n = 1'b1;
        idle(5);

        // one more op after reset to show the pipe still runs
        issue(4'd0, 32'd6, 32'd7, 32'd42, 1'b0, 1'b1);
        idle(4);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
